// File: rtl/alu_issue_if.sv
// Handshake and operand bundle between the register-read stage, the issue stage and the ALU.
// The master drives the instruction side and consumes the operation; the slave is the stage.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  wr_reg;
    logic        wr_en;
    logic        illegal;

    modport master (
        output in_valid, instr, rs_data, rt_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, wr_reg, wr_en, illegal
    );

    modport slave (
        input  in_valid, instr, rs_data, rt_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, wr_reg, wr_en, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// Single-entry issue stage: decodes a MIPS ALU/load/store/branch instruction into ALU
// operands, opcode and writeback target, held in a full-throughput valid/ready register.
module alu_issue (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);
    localparam logic [3:0] AluAddu = 4'd0;
    localparam logic [3:0] AluSubu = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluNor  = 4'd5;
    localparam logic [3:0] AluSlt  = 4'd6;
    localparam logic [3:0] AluSltu = 4'd7;
    localparam logic [3:0] AluSll  = 4'd8;
    localparam logic [3:0] AluSrl  = 4'd9;
    localparam logic [3:0] AluSra  = 4'd10;
    localparam logic [3:0] AluSllv = 4'd11;
    localparam logic [3:0] AluSrlv = 4'd12;
    localparam logic [3:0] AluSrav = 4'd13;
    localparam logic [3:0] AluLui  = 4'd14;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt, rd, shamt;
    logic [31:0] imm_sext, imm_zext;

    logic [3:0]  dec_op;
    logic [31:0] dec_a, dec_b;
    logic [4:0]  dec_reg;
    logic        dec_wen, dec_ill;

    logic        valid_q;
    logic        accept;

    assign opcode   = bus.instr[31:26];
    assign rt       = bus.instr[20:16];
    assign rd       = bus.instr[15:11];
    assign shamt    = bus.instr[10:6];
    assign funct    = bus.instr[5:0];
    assign imm_sext = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign imm_zext = {16'h0000, bus.instr[15:0]};

    assign bus.in_ready  = !valid_q | bus.out_ready;
    assign bus.out_valid = valid_q;
    assign accept        = bus.in_valid & bus.in_ready & !bus.flush;

    always_comb begin
        dec_op  = AluAddu;
        dec_a   = bus.rs_data;
        dec_b   = bus.rt_data;
        dec_reg = 5'd0;
        dec_wen = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            6'h00: begin
                dec_reg = rd;
                dec_wen = 1'b1;
                case (funct)
                    6'h21: dec_op = AluAddu;
                    6'h23: dec_op = AluSubu;
                    6'h24: dec_op = AluAnd;
                    6'h25: dec_op = AluOr;
                    6'h26: dec_op = AluXor;
                    6'h27: dec_op = AluNor;
                    6'h2A: dec_op = AluSlt;
                    6'h2B: dec_op = AluSltu;
                    6'h00: begin dec_op = AluSll; dec_a = {27'b0, shamt}; end
                    6'h02: begin dec_op = AluSrl; dec_a = {27'b0, shamt}; end
                    6'h03: begin dec_op = AluSra; dec_a = {27'b0, shamt}; end
                    6'h04: dec_op = AluSllv;
                    6'h06: dec_op = AluSrlv;
                    6'h07: dec_op = AluSrav;
                    default: dec_ill = 1'b1;
                endcase
            end
            6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                dec_op  = (opcode == 6'h0A) ? AluSlt : (opcode == 6'h0B) ? AluSltu : AluAddu;
                dec_b   = imm_sext;
                dec_reg = rt;
                dec_wen = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec_op  = (opcode == 6'h0C) ? AluAnd : (opcode == 6'h0D) ? AluOr :
                          (opcode == 6'h0E) ? AluXor : AluLui;
                dec_b   = imm_zext;
                dec_reg = rt;
                dec_wen = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: dec_b = imm_sext;
            6'h04, 6'h05:        dec_op = AluSubu;
            default:             dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_op  = AluAddu;
            dec_a   = '0;
            dec_b   = '0;
            dec_reg = 5'd0;
            dec_wen = 1'b0;
        end
        // $zero is never a real writeback target.
        if (dec_reg == 5'd0) dec_wen = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
            bus.alu_op  <= AluAddu;
            bus.wr_reg  <= 5'd0;
            bus.wr_en   <= 1'b0;
            bus.illegal <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            bus.alu_a   <= dec_a;
            bus.alu_b   <= dec_b;
            bus.alu_op  <= dec_op;
            bus.wr_reg  <= dec_reg;
            bus.wr_en   <= dec_wen;
            bus.illegal <= dec_ill;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected operations are queued at accept and compared
// against the held outputs every cycle until the downstream consumes them.
module tb_alu_issue;
    localparam logic [3:0] OpAddu = 4'd0,  OpSubu = 4'd1,  OpAnd  = 4'd2,  OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4,  OpNor  = 4'd5,  OpSlt  = 4'd6,  OpSltu = 4'd7;
    localparam logic [3:0] OpSll  = 4'd8,  OpSrl  = 4'd9,  OpSra  = 4'd10, OpSllv = 4'd11;
    localparam logic [3:0] OpSrlv = 4'd12, OpSrav = 4'd13, OpLui  = 4'd14;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rg;
        logic        wen;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    alu_issue_if bus ();

    alu_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic model_valid = 1'b0;
    exp_t pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                   input logic [31:0] rt);
        exp_t e;
        logic [5:0]  opc = ins[31:26];
        logic [5:0]  fn  = ins[5:0];
        logic [31:0] sx  = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] zx  = {16'h0, ins[15:0]};
        e = '{op: OpAddu, a: 32'h0, b: 32'h0, rg: 5'd0, wen: 1'b0, ill: 1'b1};
        if (opc == 6'h00) begin
            e = '{op: OpAddu, a: rs, b: rt, rg: ins[15:11], wen: 1'b1, ill: 1'b0};
            case (fn)
                6'h21: e.op = OpAddu;  6'h23: e.op = OpSubu;
                6'h24: e.op = OpAnd;   6'h25: e.op = OpOr;
                6'h26: e.op = OpXor;   6'h27: e.op = OpNor;
                6'h2A: e.op = OpSlt;   6'h2B: e.op = OpSltu;
                6'h04: e.op = OpSllv;  6'h06: e.op = OpSrlv;  6'h07: e.op = OpSrav;
                6'h00: begin e.op = OpSll; e.a = {27'b0, ins[10:6]}; end
                6'h02: begin e.op = OpSrl; e.a = {27'b0, ins[10:6]}; end
                6'h03: begin e.op = OpSra; e.a = {27'b0, ins[10:6]}; end
                default: e = '{op: OpAddu, a: 32'h0, b: 32'h0, rg: 5'd0, wen: 1'b0, ill: 1'b1};
            endcase
        end else if (opc inside {6'h09, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            e = '{op: OpAddu, a: rs, b: sx, rg: ins[20:16], wen: 1'b1, ill: 1'b0};
        end else if (opc == 6'h0A) begin
            e = '{op: OpSlt, a: rs, b: sx, rg: ins[20:16], wen: 1'b1, ill: 1'b0};
        end else if (opc == 6'h0B) begin
            e = '{op: OpSltu, a: rs, b: sx, rg: ins[20:16], wen: 1'b1, ill: 1'b0};
        end else if (opc == 6'h0C) begin
            e = '{op: OpAnd, a: rs, b: zx, rg: ins[20:16], wen: 1'b1, ill: 1'b0};
        end else if (opc == 6'h0D) begin
            e = '{op: OpOr, a: rs, b: zx, rg: ins[20:16], wen: 1'b1, ill: 1'b0};
        end else if (opc == 6'h0E) begin
            e = '{op: OpXor, a: rs, b: zx, rg: ins[20:16], wen: 1'b1, ill: 1'b0};
        end else if (opc == 6'h0F) begin
            e = '{op: OpLui, a: rs, b: zx, rg: ins[20:16], wen: 1'b1, ill: 1'b0};
        end else if (opc inside {6'h28, 6'h29, 6'h2B}) begin
            e = '{op: OpAddu, a: rs, b: sx, rg: 5'd0, wen: 1'b0, ill: 1'b0};
        end else if (opc inside {6'h04, 6'h05}) begin
            e = '{op: OpSubu, a: rs, b: rt, rg: 5'd0, wen: 1'b0, ill: 1'b0};
        end
        if (e.rg == 5'd0) e.wen = 1'b0;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input logic fl, input logic ordy);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.rs_data   = rs;
        bus.rt_data   = rt;
        bus.flush     = fl;
        bus.out_ready = ordy;
        pending       = model(ins, rs, rt);
    endtask

    // Inputs are already applied; check held outputs, advance the model, cross the edge.
    task automatic step();
        logic acc;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(!model_valid | bus.out_ready));
        check("out_valid", 32'(bus.out_valid), 32'(model_valid));
        if (model_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'(1), 32'(0));
            end else begin
                check("alu_op", 32'(bus.alu_op), 32'(sb_q[0].op));
                check("alu_a", bus.alu_a, sb_q[0].a);
                check("alu_b", bus.alu_b, sb_q[0].b);
                check("wr_reg", 32'(bus.wr_reg), 32'(sb_q[0].rg));
                check("wr_en", 32'(bus.wr_en), 32'(sb_q[0].wen));
                check("illegal", 32'(bus.illegal), 32'(sb_q[0].ill));
                if (bus.out_ready) void'(sb_q.pop_front());
            end
        end
        acc = bus.in_valid & !bus.flush & (!model_valid | bus.out_ready);
        if (bus.flush) begin
            sb_q.delete();
            model_valid = 1'b0;
        end else if (acc) begin
            sb_q.push_back(pending);
            model_valid = 1'b1;
        end else if (bus.out_ready) begin
            model_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    logic [5:0] opc_tab[21] = '{6'h00, 6'h00, 6'h00, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29,
                                6'h2B, 6'h04, 6'h05, 6'h3F};
    logic [5:0] fn_tab[16] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h1A};

    initial begin
        logic [31:0] ins;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_alu_a", bus.alu_a, 32'h0);
        check("rst_alu_b", bus.alu_b, 32'h0);
        check("rst_alu_op", 32'(bus.alu_op), 32'(OpAddu));
        check("rst_wr_reg", 32'(bus.wr_reg), 32'(0));
        check("rst_wr_en", 32'(bus.wr_en), 32'(0));
        check("rst_illegal", 32'(bus.illegal), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived expectations.
        drive(1'b1, 32'h00221821, 32'd5, 32'd7, 1'b0, 1'b1);
        pending = '{op: OpAddu, a: 32'd5, b: 32'd7, rg: 5'd3, wen: 1'b1, ill: 1'b0};
        step();
        drive(1'b1, 32'h2422FFFF, 32'd9, 32'd0, 1'b0, 1'b1);
        pending = '{op: OpAddu, a: 32'd9, b: 32'hFFFFFFFF, rg: 5'd2, wen: 1'b1, ill: 1'b0};
        step();
        drive(1'b1, 32'h3422FFFF, 32'd9, 32'd0, 1'b0, 1'b1);
        pending = '{op: OpOr, a: 32'd9, b: 32'h0000FFFF, rg: 5'd2, wen: 1'b1, ill: 1'b0};
        step();
        drive(1'b1, 32'h3C021234, 32'd0, 32'd0, 1'b0, 1'b1);
        pending = '{op: OpLui, a: 32'd0, b: 32'h00001234, rg: 5'd2, wen: 1'b1, ill: 1'b0};
        step();
        drive(1'b1, 32'h00011100, 32'hDEAD, 32'h1, 1'b0, 1'b1);
        pending = '{op: OpSll, a: 32'd4, b: 32'd1, rg: 5'd2, wen: 1'b1, ill: 1'b0};
        step();
        drive(1'b1, 32'h00221807, 32'h11, 32'h80000000, 1'b0, 1'b1);
        pending = '{op: OpSrav, a: 32'h11, b: 32'h80000000, rg: 5'd3, wen: 1'b1, ill: 1'b0};
        step();
        drive(1'b1, 32'hFC000000, 32'h5, 32'h6, 1'b0, 1'b1);
        pending = '{op: OpAddu, a: 32'h0, b: 32'h0, rg: 5'd0, wen: 1'b0, ill: 1'b1};
        step();
        drive(1'b1, 32'h00220021, 32'h5, 32'h6, 1'b0, 1'b1);
        pending = '{op: OpAddu, a: 32'h5, b: 32'h6, rg: 5'd0, wen: 1'b0, ill: 1'b0};
        step();

        // Stall three cycles with a new instruction waiting, then release with no gap.
        drive(1'b1, 32'h00432023, 32'd20, 32'd3, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00432824, 32'hF0F0, 32'hFF00, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h00432824, 32'hF0F0, 32'hFF00, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();

        // Flush drops both the held and the incoming instruction.
        drive(1'b1, 32'h00432825, 32'd1, 32'd2, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h00432826, 32'd1, 32'd2, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();

        // Asynchronous reset while stalled.
        drive(1'b1, 32'h2465FFF0, 32'd100, 32'd0, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h24660001, 32'd100, 32'd0, 1'b0, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'(0));
        check("async_rst_alu_a", bus.alu_a, 32'h0);
        check("async_rst_wr_en", 32'(bus.wr_en), 32'(0));
        sb_q.delete();
        model_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h24660001, 32'd100, 32'd0, 1'b0, 1'b1);
        #3;
        step();

        // Randomised mix of instructions, stalls and flushes.
        for (int i = 0; i < 300; i++) begin
            logic [5:0] opc;
            ins = $urandom();
            opc = opc_tab[$urandom_range(0, 20)];
            ins[31:26] = opc;
            if (opc == 6'h00) ins[5:0] = fn_tab[$urandom_range(0, 15)];
            drive(1'($urandom_range(0, 3) != 0), ins, $urandom(), $urandom(),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
